// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle a - b - bin, one nibble per clock through a single 4-bit borrow-lookahead slice.
// Optional signed overflow output is built only when NIBBLE_SUB_OVF_EN is defined.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o,
  output logic             zero_o,
  output logic             ovf_o
);
  localparam int N    = WIDTH / 4;
  localparam int IDXW = $clog2(N);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d, diff_nxt;
  logic             br_q, br_d, bout_q, bout_d, zero_q, zero_d;
  logic             accept, last;
  logic [3:0]       a4, b4, g, p, d4;
  logic [4:0]       c;

  assign accept = start_i && (state_q != BUSY);
  assign last   = (state_q == BUSY) && (idx_q == IDXW'(N-1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = BUSY;
      BUSY:    if (last)    state_d = DONE;
      DONE:    state_d = start_i ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == BUSY);
    done_o = (state_q == DONE);
  end

  // Borrow lookahead: generate when a<b, propagate when a==b, flattened per bit.
  always_comb begin
    a4   = a_q[{idx_q, 2'b00} +: 4];
    b4   = b_q[{idx_q, 2'b00} +: 4];
    g    = ~a4 & b4;
    p    = ~(a4 ^ b4);
    c[0] = br_q;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    d4   = a4 ^ b4 ^ c[3:0];
    diff_nxt = diff_q;
    diff_nxt[{idx_q, 2'b00} +: 4] = d4;
  end

`ifdef NIBBLE_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    br_d   = br_q;
    idx_d  = idx_q;
    diff_d = diff_q;
    bout_d = bout_q;
    zero_d = zero_q;
`ifdef NIBBLE_SUB_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (accept) begin
      a_d    = a_i;
      b_d    = b_i;
      br_d   = bin_i;
      idx_d  = '0;
      diff_d = '0;
      bout_d = 1'b0;
      zero_d = 1'b0;
`ifdef NIBBLE_SUB_OVF_EN
      ovf_d  = 1'b0;
`endif
    end else if (state_q == BUSY) begin
      diff_d = diff_nxt;
      br_d   = c[4];
      idx_d  = idx_q + 1'b1;
      if (last) begin
        bout_d = c[4];
        zero_d = (diff_nxt == '0);
`ifdef NIBBLE_SUB_OVF_EN
        ovf_d  = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (diff_nxt[WIDTH-1] != a_q[WIDTH-1]);
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      a_q    <= '0;
      b_q    <= '0;
      br_q   <= 1'b0;
      idx_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      br_q   <= br_d;
      idx_q  <= idx_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
    end
  end

`ifdef NIBBLE_SUB_OVF_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

  assign diff_o = diff_q;
  assign bout_o = bout_q;
  assign zero_o = zero_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed checks of the nibble-serial subtractor at WIDTH=16 and WIDTH=8.
module tb_nibble_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, bin16, busy16, done16, bout16, zero16, ovf16;
  logic [15:0] a16, b16, diff16;
  logic        start8, bin8, busy8, done8, bout8, zero8, ovf8;
  logic [7:0]  a8, b8, diff8;
  int          checks = 0;
  int          errors = 0;
  int          bcy, gap;
  logic        ovf_exp;

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start16), .a_i(a16), .b_i(b16), .bin_i(bin16),
    .busy_o(busy16), .done_o(done16), .diff_o(diff16), .bout_o(bout16), .zero_o(zero16), .ovf_o(ovf16));

  nibble_serial_subtractor #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
    .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8), .zero_o(zero8), .ovf_o(ovf8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Pulse start, count busy cycles, return positioned in the done cycle (bounded wait).
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi, output int nb);
    a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
    step();
    start16 = 1'b0;
    nb = 0;
    for (int i = 0; i < 20 && !done16; i++) begin
      if (busy16) nb++;
      step();
    end
    chk("done16", {31'd0, done16}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start16 = 1'b0; start8 = 1'b0;
    a16 = '0; b16 = '0; bin16 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    step(); step();
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_done", {31'd0, done16}, 32'd0);
    chk("rst_diff", {16'd0, diff16}, 32'd0);
    chk("rst_flags", {29'd0, bout16, zero16, ovf16}, 32'd0);
    rst_n = 1'b1;
    step();

    op16(16'h1234, 16'h0234, 1'b0, bcy);
    chk("c1_busycy", bcy, 32'd4);
    chk("c1_diff", {16'd0, diff16}, 32'h1000);
    chk("c1_flags", {29'd0, bout16, zero16, ovf16}, 32'd0);
    step();
    chk("c1_donepulse", {31'd0, done16}, 32'd0);
    chk("c1_hold", {16'd0, diff16}, 32'h1000);

    op16(16'h0000, 16'h0001, 1'b0, bcy);
    chk("c2_diff", {16'd0, diff16}, 32'hFFFF);
    chk("c2_bout", {31'd0, bout16}, 32'd1);
    chk("c2_zero", {31'd0, zero16}, 32'd0);
    step();

`ifdef NIBBLE_SUB_OVF_EN
    ovf_exp = 1'b1;
`else
    ovf_exp = 1'b0;
`endif
    op16(16'h8000, 16'h0001, 1'b0, bcy);
    chk("c3_diff", {16'd0, diff16}, 32'h7FFF);
    chk("c3_bout", {31'd0, bout16}, 32'd0);
    chk("c3_ovf", {31'd0, ovf16}, {31'd0, ovf_exp});
    step();

    op16(16'h5555, 16'h5554, 1'b1, bcy);
    chk("c4_diff", {16'd0, diff16}, 32'h0000);
    chk("c4_zero", {31'd0, zero16}, 32'd1);
    chk("c4_bout", {31'd0, bout16}, 32'd0);
    a16 = 16'h0003; b16 = 16'h0001; bin16 = 1'b0; start16 = 1'b1;
    step();
    chk("c4_b2b_busy", {31'd0, busy16}, 32'd1);
    gap = 1;
    for (int i = 0; i < 20 && !done16; i++) begin
      step();
      gap++;
    end
    start16 = 1'b0;
    chk("c4_gap", gap, 32'd5);
    chk("c4_diff2", {16'd0, diff16}, 32'h0002);
    chk("c4_zero2", {31'd0, zero16}, 32'd0);
    step();

    // Abort mid-operation: extra start during BUSY, then reset on the 3rd busy cycle.
    a16 = 16'hFFFF; b16 = 16'h1111; bin16 = 1'b0; start16 = 1'b1;
    step();
    a16 = 16'h0000; b16 = 16'h0001;
    step();
    start16 = 1'b0;
    step();
    chk("c5_busy3", {31'd0, busy16}, 32'd1);
    chk("c5_partial", {16'd0, diff16}, 32'h00EE);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("c5_rbusy", {31'd0, busy16}, 32'd0);
    chk("c5_rdone", {31'd0, done16}, 32'd0);
    chk("c5_rdiff", {16'd0, diff16}, 32'd0);
    chk("c5_rbout", {31'd0, bout16}, 32'd0);
    op16(16'hFFFF, 16'h1111, 1'b0, bcy);
    chk("c5_diff", {16'd0, diff16}, 32'hEEEE);
    chk("c5_bout", {31'd0, bout16}, 32'd0);
    step();

    a8 = 8'h10; b8 = 8'h20; bin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    bcy = 0;
    for (int i = 0; i < 20 && !done8; i++) begin
      if (busy8) bcy++;
      step();
    end
    chk("w8_done", {31'd0, done8}, 32'd1);
    chk("w8_busycy", bcy, 32'd2);
    chk("w8_diff", {24'd0, diff8}, 32'h00F0);
    chk("w8_bout", {31'd0, bout8}, 32'd1);
    chk("w8_ovf", {31'd0, ovf8}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
